// File: rtl/hamming74_serial_encoder.sv
// Hamming(7,4) serial encoder: accepts nibbles over valid/ready, shifts 7-bit codewords out LSB-first,
// BIT_CYCLES clocks per bit, with a one-word holding register for gap-free back-to-back transmission.
module hamming74_serial_encoder #(
   parameter int   BIT_CYCLES = 1,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [3:0] data_in,
   input  logic       data_valid,
   output logic       data_ready,
   output logic       enc_out,
   output logic       enc_frame,
   output logic       busy
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   localparam logic [7:0] BIT_TERM = 8'(BIT_CYCLES - 1);

   function automatic logic [6:0] hamming_encode(input logic [3:0] d);
      logic p1;
      logic p2;
      logic p4;
      p1 = d[0] ^ d[1] ^ d[3];
      p2 = d[0] ^ d[2] ^ d[3];
      p4 = d[1] ^ d[2] ^ d[3];
      return {d[3], d[2], d[1], p4, d[0], p2, p1};
   endfunction

   state_t     state_r, state_nx;
   logic [6:0] shift_r, shift_nx;
   logic [6:0] hold_r, hold_nx;
   logic       hold_full_r, hold_full_nx;
   logic [2:0] bit_idx_r, bit_idx_nx;
   logic [7:0] timer_r, timer_nx;
   logic       enc_out_r, enc_out_nx;
   logic       enc_frame_r, enc_frame_nx;

   logic       accept_s;
   logic       bit_done_s;
   logic       word_end_s;
   logic [2:0] next_idx_s;
   logic [6:0] cw_in_s;

   assign data_ready = ena & ~hold_full_r;
   assign accept_s   = data_valid & data_ready;
   assign bit_done_s = (timer_r == BIT_TERM);
   assign word_end_s = bit_done_s & (bit_idx_r == 3'd6);
   assign next_idx_s = bit_idx_r + 3'd1;
   assign cw_in_s    = hamming_encode(data_in);
   assign enc_out    = enc_out_r;
   assign enc_frame  = enc_frame_r;
   assign busy       = (state_r == SEND) | hold_full_r;

   // Next-state logic for the transmit FSM, shifter, timer and holding register
   always_comb begin
      state_nx     = state_r;
      shift_nx     = shift_r;
      hold_nx      = hold_r;
      hold_full_nx = hold_full_r;
      bit_idx_nx   = bit_idx_r;
      timer_nx     = timer_r;
      enc_out_nx   = enc_out_r;
      enc_frame_nx = enc_frame_r;
      if (ena) begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  shift_nx     = cw_in_s;
                  bit_idx_nx   = 3'd0;
                  timer_nx     = 8'd0;
                  state_nx     = SEND;
                  enc_out_nx   = cw_in_s[0];
                  enc_frame_nx = 1'b1;
               end else begin
                  enc_out_nx   = IDLE_LEVEL;
                  enc_frame_nx = 1'b0;
               end
            end
            SEND: begin
               if (bit_done_s) begin
                  timer_nx = 8'd0;
                  if (bit_idx_r == 3'd6) begin
                     bit_idx_nx = 3'd0;
                     if (hold_full_r) begin
                        shift_nx     = hold_r;
                        hold_full_nx = 1'b0;
                        enc_out_nx   = hold_r[0];
                        enc_frame_nx = 1'b1;
                     end else if (accept_s) begin
                        // a word accepted on the last edge of a codeword goes straight to the shifter
                        shift_nx     = cw_in_s;
                        enc_out_nx   = cw_in_s[0];
                        enc_frame_nx = 1'b1;
                     end else begin
                        state_nx     = IDLE;
                        enc_out_nx   = IDLE_LEVEL;
                        enc_frame_nx = 1'b0;
                     end
                  end else begin
                     bit_idx_nx   = next_idx_s;
                     enc_out_nx   = shift_r[next_idx_s];
                     enc_frame_nx = 1'b0;
                  end
               end else begin
                  timer_nx = timer_r + 8'd1;
               end
               if (accept_s && !word_end_s) begin
                  hold_nx      = cw_in_s;
                  hold_full_nx = 1'b1;
               end else begin
                  hold_nx = hold_nx;
               end
            end
            default: begin
               state_nx     = IDLE;
               enc_out_nx   = IDLE_LEVEL;
               enc_frame_nx = 1'b0;
            end
         endcase
      end else begin
         state_nx = state_r;
      end
   end

   // State register with asynchronous clear of the whole transmit path
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         shift_r     <= 7'd0;
         hold_r      <= 7'd0;
         hold_full_r <= 1'b0;
         bit_idx_r   <= 3'd0;
         timer_r     <= 8'd0;
         enc_out_r   <= IDLE_LEVEL;
         enc_frame_r <= 1'b0;
      end else begin
         state_r     <= state_nx;
         shift_r     <= shift_nx;
         hold_r      <= hold_nx;
         hold_full_r <= hold_full_nx;
         bit_idx_r   <= bit_idx_nx;
         timer_r     <= timer_nx;
         enc_out_r   <= enc_out_nx;
         enc_frame_r <= enc_frame_nx;
      end
   end

endmodule

// File: tb/tb_hamming74_serial_encoder.sv
// Bench for hamming74_serial_encoder: two instances (1 clk/bit idle-low, 4 clk/bit idle-high) driven
// together and checked against a word-queue reference model, vector tables and directed sequences.
module tb_hamming74_serial_encoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [3:0] data_in;
   logic       data_valid;
   logic [1:0] dr, eo, ef, bz;

   int   bc[2] = '{1, 4};
   logic il[2] = '{1'b0, 1'b1};

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: up to two queued codewords per instance, position in the front word in clocks
   logic [6:0] mw[2][2];
   int         mcnt[2];
   int         mpos[2];
   logic       macc[2];

   // loopback capture
   logic       lb_on = 1'b0;
   int         rx_n  = 7;
   logic [6:0] rx_w;
   int         lb_count = 0;
   logic [3:0] sent_q[$];

   typedef struct {
      logic       v;
      logic [3:0] d;
      logic       eo;
      logic       ef;
      logic       rdy;
   } vec_t;
   vec_t tbl[$];

   always #5 clk = ~clk;

   hamming74_serial_encoder #(.BIT_CYCLES(1), .IDLE_LEVEL(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in), .data_valid(data_valid),
      .data_ready(dr[0]), .enc_out(eo[0]), .enc_frame(ef[0]), .busy(bz[0]));

   hamming74_serial_encoder #(.BIT_CYCLES(4), .IDLE_LEVEL(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in), .data_valid(data_valid),
      .data_ready(dr[1]), .enc_out(eo[1]), .enc_frame(ef[1]), .busy(bz[1]));

   // Hamming codeword from its textbook definition: parity bit 2^k covers positions with bit k set
   function automatic logic [6:0] ref_cw(input logic [3:0] d);
      logic [7:0] w;
      logic       p;
      w    = 8'd0;
      w[3] = d[0];
      w[5] = d[1];
      w[6] = d[2];
      w[7] = d[3];
      for (int k = 0; k < 3; k++) begin
         p = 1'b0;
         for (int pos = 1; pos < 8; pos++)
            if ((pos & (1 << k)) != 0) p = p ^ w[pos];
         w[1 << k] = p;
      end
      return w[7:1];
   endfunction

   task automatic chk(input string nm, input int inst, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s inst%0d actual=%0d expected=%0d at %0t", nm, inst, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mcnt[i] = 0;
         mpos[i] = 0;
         macc[i] = 1'b0;
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         macc[i] = 1'b0;
         if (ena) begin
            macc[i] = data_valid && (mcnt[i] < 2);
            if (mcnt[i] > 0) begin
               mpos[i]++;
               if (mpos[i] == 7 * bc[i]) begin
                  mw[i][0] = mw[i][1];
                  mcnt[i]--;
                  mpos[i] = 0;
               end
            end
            if (macc[i]) begin
               mw[i][mcnt[i]] = ref_cw(data_in);
               mcnt[i]++;
            end
         end
      end
      if (lb_on && macc[0]) sent_q.push_back(data_in);
   endtask

   task automatic loopback_sample();
      logic [2:0] syn;
      if (ef[0]) rx_n = 0;
      if (rx_n < 7) begin
         rx_w[rx_n] = eo[0];
         rx_n++;
         if (rx_n == 7) begin
            syn = 3'd0;
            for (int p = 1; p < 8; p++)
               if (rx_w[p-1]) syn = syn ^ 3'(p);
            chk("lb_syndrome", 0, {5'd0, syn}, 8'd0);
            if (sent_q.size() > 0)
               chk("lb_decoded", 0, {4'd0, rx_w[6], rx_w[5], rx_w[4], rx_w[2]}, {4'd0, sent_q.pop_front()});
            else
               chk("lb_unexpected_word", 0, 8'd1, 8'd0);
            lb_count++;
         end
      end
   endtask

   // compare both instances against the model, then advance one clock
   task automatic tick();
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("enc_out", i, {7'd0, eo[i]},
             {7'd0, (mcnt[i] > 0) ? mw[i][0][mpos[i] / bc[i]] : il[i]});
         chk("enc_frame", i, {7'd0, ef[i]}, {7'd0, (mcnt[i] > 0) && (mpos[i] < bc[i])});
         chk("busy", i, {7'd0, bz[i]}, {7'd0, mcnt[i] > 0});
         chk("data_ready", i, {7'd0, dr[i]}, {7'd0, ena && (mcnt[i] < 2)});
      end
      if (lb_on) loopback_sample();
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
   endtask

   task automatic add_row(input logic v, input logic [3:0] d, input logic e, input logic f, input logic r);
      vec_t t;
      t.v = v; t.d = d; t.eo = e; t.ef = f; t.rdy = r;
      tbl.push_back(t);
   endtask

   initial begin
      int idx;
      logic [6:0] c9;
      rst_n = 1'b0; ena = 1'b1; data_valid = 1'b0; data_in = 4'd0;
      model_reset();
      @(negedge clk);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // test 1: 4'b1011 -> 1010101 LSB-first; test 2: 0001 then 1111 back-to-back
      add_row(1'b1, 4'b1011, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 7; k++) add_row(1'b0, 4'd0, (k % 2 == 0), (k == 0), 1'b1);
      add_row(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      add_row(1'b1, 4'b0001, 1'b0, 1'b0, 1'b1);
      add_row(1'b1, 4'b1111, 1'b1, 1'b1, 1'b1);
      add_row(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      add_row(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) add_row(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 7; k++) add_row(1'b0, 4'd0, 1'b1, (k == 0), 1'b1);
      add_row(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      foreach (tbl[j]) begin
         data_valid = tbl[j].v;
         data_in    = tbl[j].d;
         #1;
         chk("tbl_enc_out", j, {7'd0, eo[0]}, {7'd0, tbl[j].eo});
         chk("tbl_enc_frame", j, {7'd0, ef[0]}, {7'd0, tbl[j].ef});
         chk("tbl_data_ready", j, {7'd0, dr[0]}, {7'd0, tbl[j].rdy});
         tick();
      end

      // test 3: 4 clocks/bit, idle-high line, all-zero word
      data_valid = 1'b0;
      for (int k = 0; k < 40; k++) tick();
      data_valid = 1'b1; data_in = 4'b0000;
      tick();
      data_valid = 1'b0;
      for (int k = 0; k < 28; k++) begin
         #1;
         chk("t3_zero_bit", k, {7'd0, eo[1]}, 8'd0);
         chk("t3_busy", k, {7'd0, bz[1]}, 8'd1);
         tick();
      end
      #1;
      chk("t3_idle_level", 0, {7'd0, eo[1]}, 8'd1);
      chk("t3_busy_end", 0, {7'd0, bz[1]}, 8'd0);
      for (int k = 0; k < 5; k++) tick();

      // test 4: ena low for 5 cycles during bit 3 of 4'b1011
      data_valid = 1'b1; data_in = 4'b1011;
      tick();
      data_valid = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      ena = 1'b0; data_valid = 1'b1; data_in = 4'b0101;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("t4_bit3_held", k, {7'd0, eo[0]}, 8'd0);
         chk("t4_no_ready", k, {7'd0, dr[0]}, 8'd0);
         tick();
      end
      ena = 1'b1; data_valid = 1'b0;
      for (int k = 0; k < 40; k++) tick();

      // test 5: reset during bit 4 with a word held
      data_valid = 1'b1; data_in = 4'b0011;
      tick();
      data_in = 4'b1100;
      tick();
      data_valid = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("t5_line_idle", 0, {7'd0, eo[0]}, 8'd0);
      chk("t5_busy_clear", 0, {7'd0, bz[0]}, 8'd0);
      tick();
      rst_n = 1'b1;
      data_valid = 1'b1; data_in = 4'b1001;
      tick();
      data_valid = 1'b0;
      c9 = ref_cw(4'b1001);
      #1;
      chk("t5_restart_c0", 0, {7'd0, eo[0]}, {7'd0, c9[0]});
      chk("t5_restart_frame", 0, {7'd0, ef[0]}, 8'd1);
      for (int k = 0; k < 40; k++) tick();

      // test 6: loopback of all 16 nibbles, back-to-back
      lb_on = 1'b1;
      idx = 0;
      for (int k = 0; k < 140; k++) begin
         data_valid = (idx < 16);
         data_in    = 4'(idx);
         tick();
         if (macc[0]) idx++;
      end
      lb_on = 1'b0;
      data_valid = 1'b0;
      chk("lb_words_received", 0, 8'(lb_count), 8'd16);
      for (int k = 0; k < 40; k++) tick();

      // randomized traffic with ena stalls
      for (int k = 0; k < 1500; k++) begin
         ena        = ($urandom_range(0, 9) != 0);
         data_valid = ($urandom_range(0, 2) != 0);
         data_in    = 4'($urandom_range(0, 15));
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
